// File: rtl/btn_move_gen.sv
`default_nettype none
// ============================================================================
//  Module   : btn_move_gen
//  Purpose  : Conditions four raw push buttons into one-cycle one-hot move
//             codes (8=U, 4=D, 2=R, 1=L). Supports hold-to-repeat, a
//             lockout window after player death and a disable input.
//  Revision : 1.0  initial release
// ============================================================================
module btn_move_gen #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 32,
    parameter int REPEAT_PERIOD   = 8,
    parameter int LOCKOUT_CYCLES  = 64,
    parameter int CNT_W           = 16
) (
    input  logic       btnClk,
    input  logic       rst,
    input  logic       btnU,
    input  logic       btnD,
    input  logic       btnR,
    input  logic       btnL,
    input  logic       playerDisable,
    input  logic       player_dead,
    output logic [3:0] btns,
    output logic [3:0] btnsStable,
    output logic       lockout
);

    // Terminal values of the counters, pre-sized to the counter width.
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_FIRST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_NEXT  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HOLD     = 2'd1,
        S_LOCKOUT  = 2'd2,
        S_WAIT_REL = 2'd3
    } state_t;

    logic [3:0]       raw;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       stable_bits;
    logic [3:0]       code;
    logic [3:0]       last;
    logic [CNT_W-1:0] rcnt;
    logic [CNT_W-1:0] lcnt;
    logic             first_rep;
    state_t           state;

    // Bit order {U,D,R,L} matches the one-hot code weights.
    assign raw = {btnU, btnD, btnR, btnL};

    // Two-flop synchronizer for the asynchronous raw buttons.
    always_ff @(posedge btnClk or posedge rst) begin
        if (rst) begin
            sync1 <= 4'b0000;
            sync2 <= 4'b0000;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_bit
        logic [CNT_W-1:0] cnt;
        logic             stb;

        // Flip the stable level only after a full run of disagreeing samples.
        always_ff @(posedge btnClk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
                stb <= 1'b0;
            end else if (sync2[i] != stb) begin
                if (cnt == DB_LAST) begin
                    stb <= sync2[i];
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end

        assign stable_bits[i] = stb;
    end

    assign btnsStable = stable_bits;

    // Priority select U > D > R > L from the debounced levels.
    always_comb begin
        code = 4'b0000;
        if (stable_bits[3])      code = 4'b1000;
        else if (stable_bits[2]) code = 4'b0100;
        else if (stable_bits[1]) code = 4'b0010;
        else if (stable_bits[0]) code = 4'b0001;
    end

    // Move FSM: press, auto-repeat, lockout and wait-for-release handling.
    always_ff @(posedge btnClk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            btns      <= 4'b0000;
            last      <= 4'b0000;
            rcnt      <= '0;
            lcnt      <= '0;
            first_rep <= 1'b0;
            lockout   <= 1'b0;
        end else begin
            btns <= 4'b0000;
            if (player_dead) begin
                // Death wins over everything, and re-arms a running lockout.
                state   <= S_LOCKOUT;
                lcnt    <= '0;
                lockout <= 1'b1;
            end else if (playerDisable) begin
                // Keys held at re-enable must be released first.
                state   <= S_WAIT_REL;
                lockout <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (code != 4'b0000) begin
                            btns      <= code;
                            last      <= code;
                            rcnt      <= '0;
                            first_rep <= 1'b1;
                            state     <= S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (code == 4'b0000) begin
                            state <= S_IDLE;
                        end else if (code != last) begin
                            btns      <= code;
                            last      <= code;
                            rcnt      <= '0;
                            first_rep <= 1'b1;
                        end else if ((first_rep && rcnt == REP_FIRST) ||
                                     (!first_rep && rcnt == REP_NEXT)) begin
                            btns      <= last;
                            rcnt      <= '0;
                            first_rep <= 1'b0;
                        end else if (rcnt != CNT_MAX) begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end
                    S_LOCKOUT: begin
                        if (lcnt == LOCK_LAST) begin
                            state   <= S_WAIT_REL;
                            lockout <= 1'b0;
                        end else if (lcnt != CNT_MAX) begin
                            lcnt <= lcnt + 1'b1;
                        end
                    end
                    S_WAIT_REL: begin
                        if (code == 4'b0000) begin
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        state   <= S_IDLE;
                        lockout <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_btn_move_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btn_move_gen
//  Purpose  : Directed and randomized bench for btn_move_gen with an
//             event-time reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_btn_move_gen;

    localparam int DEB  = 16;
    localparam int RDLY = 32;
    localparam int RPER = 8;
    localparam int LOCK = 64;

    localparam int M_IDLE = 0;
    localparam int M_HOLD = 1;
    localparam int M_LOCK = 2;
    localparam int M_WAIT = 3;

    logic       btnClk = 1'b0;
    logic       rst = 1'b1;
    logic       btnU = 1'b0, btnD = 1'b0, btnR = 1'b0, btnL = 1'b0;
    logic       playerDisable = 1'b0;
    logic       player_dead = 1'b0;
    logic [3:0] btns;
    logic [3:0] btnsStable;
    logic       lockout;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: absolute-time events rather than counters.
    int         cyc;
    logic [3:0] m_s1, m_s2, m_stable, m_btns;
    logic       m_lock;
    int         dis_since [4];
    int         mode, last, next_rep, lock_end;

    btn_move_gen #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RDLY),
        .REPEAT_PERIOD  (RPER),
        .LOCKOUT_CYCLES (LOCK),
        .CNT_W          (16)
    ) dut (
        .btnClk       (btnClk),
        .rst          (rst),
        .btnU         (btnU),
        .btnD         (btnD),
        .btnR         (btnR),
        .btnL         (btnL),
        .playerDisable(playerDisable),
        .player_dead  (player_dead),
        .btns         (btns),
        .btnsStable   (btnsStable),
        .lockout      (lockout)
    );

    always #5 btnClk = ~btnClk;

    function automatic int code_of(input logic [3:0] st);
        if (st[3]) return 8;
        if (st[2]) return 4;
        if (st[1]) return 2;
        if (st[0]) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_s1 = 4'b0; m_s2 = 4'b0; m_stable = 4'b0; m_btns = 4'b0; m_lock = 1'b0;
        for (int i = 0; i < 4; i++) dis_since[i] = -1;
        mode = M_IDLE; last = 0; next_rep = 0; lock_end = 0;
    endtask

    // One rising edge of the reference: all decisions use pre-edge values.
    task automatic model_edge(input logic [3:0] r, input logic dis, input logic dead);
        int         c;
        logic [3:0] nst;
        c   = code_of(m_stable);
        nst = m_stable;
        for (int i = 0; i < 4; i++) begin
            if (m_s2[i] != m_stable[i]) begin
                if (dis_since[i] < 0) dis_since[i] = cyc;
                if (cyc - dis_since[i] >= DEB - 1) begin
                    nst[i]       = m_s2[i];
                    dis_since[i] = -1;
                end
            end else begin
                dis_since[i] = -1;
            end
        end
        m_btns = 4'b0;
        if (dead) begin
            mode = M_LOCK; lock_end = cyc + LOCK;
        end else if (dis) begin
            mode = M_WAIT;
        end else begin
            case (mode)
                M_IDLE: if (c != 0) begin
                    m_btns = 4'(c); last = c; next_rep = cyc + RDLY; mode = M_HOLD;
                end
                M_HOLD: begin
                    if (c == 0) mode = M_IDLE;
                    else if (c != last) begin
                        m_btns = 4'(c); last = c; next_rep = cyc + RDLY;
                    end else if (cyc == next_rep) begin
                        m_btns = 4'(last); next_rep = cyc + RPER;
                    end
                end
                M_LOCK: if (cyc == lock_end) mode = M_WAIT;
                default: if (c == 0) mode = M_IDLE;
            endcase
        end
        m_lock   = (mode == M_LOCK);
        m_stable = nst;
        m_s2     = m_s1;
        m_s1     = r;
    endtask

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Advance one clock, update the model, compare on the falling edge.
    task automatic step();
        @(posedge btnClk);
        if (rst) model_reset();
        else model_edge({btnU, btnD, btnR, btnL}, playerDisable, player_dead);
        cyc++;
        @(negedge btnClk);
        check4("btns", btns, m_btns);
        check4("btnsStable", btnsStable, m_stable);
        check4("lockout", {3'b0, lockout}, {3'b0, m_lock});
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Asynchronous reset pulse applied between edges.
    task automatic async_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check4("rst_btns", btns, 4'b0);
        check4("rst_stable", btnsStable, 4'b0);
        check4("rst_lockout", {3'b0, lockout}, 4'b0);
        run(2);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] pat, r;
        int         len, dead_at;
        logic       bouncy;
        cyc = 0;
        model_reset();
        #1;
        check4("init_btns", btns, 4'b0);
        check4("init_stable", btnsStable, 4'b0);
        check4("init_lockout", {3'b0, lockout}, 4'b0);
        run(3);
        rst = 1'b0;
        run(4);

        // Clean U press: first pulse exactly on edge 3+DEB.
        btnU = 1'b1;
        run(DEB + 2);
        check4("latency_before", btns, 4'b0);
        run(1);
        check4("latency_edge", btns, 4'b1000);
        run(10);
        btnU = 1'b0;
        run(40);

        // R held well past the first pulse: delay then period repeats.
        btnR = 1'b1;
        run(DEB + 3 + 100);
        btnR = 1'b0;
        run(30);

        // Bouncy L shorter than the debounce window.
        for (int k = 0; k < 12; k++) begin
            btnL = ~btnL;
            run(5);
        end
        btnL = 1'b0;
        run(20);

        // D held, then U added on top.
        btnD = 1'b1;
        run(40);
        btnU = 1'b1;
        run(60);
        btnU = 1'b0; btnD = 1'b0;
        run(30);

        // Death pulse while R held, then release and re-press.
        btnR = 1'b1;
        run(30);
        player_dead = 1'b1;
        run(1);
        player_dead = 1'b0;
        run(90);
        btnR = 1'b0;
        run(30);
        btnR = 1'b1;
        run(25);
        btnR = 1'b0;
        run(30);

        // Reset mid-repeat, then reset during disable with U held.
        btnR = 1'b1;
        run(60);
        async_reset();
        run(40);
        btnR = 1'b0;
        run(30);
        playerDisable = 1'b1;
        btnU = 1'b1;
        run(30);
        async_reset();
        run(30);
        playerDisable = 1'b0;
        run(40);
        btnU = 1'b0;
        run(30);
        btnU = 1'b1;
        run(25);
        btnU = 1'b0;
        run(30);

        // Randomized segments: key combos, bounce, disable and death pulses.
        for (int seg = 0; seg < 80; seg++) begin
            pat           = 4'($urandom_range(0, 15));
            len           = $urandom_range(1, 90);
            bouncy        = ($urandom_range(0, 3) == 0);
            playerDisable = ($urandom_range(0, 5) == 0);
            dead_at       = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1;
            for (int k = 0; k < len; k++) begin
                r = pat;
                if (bouncy && $urandom_range(0, 7) == 0) r = r ^ 4'($urandom_range(1, 15));
                {btnU, btnD, btnR, btnL} = r;
                player_dead = (k == dead_at);
                step();
            end
            player_dead = 1'b0;
        end
        playerDisable = 1'b0;
        {btnU, btnD, btnR, btnL} = 4'b0;
        run(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
